// File: rtl/fp_div_pkg.sv
// Shared constants and types for the sequential binary32 divider.
package fp_div_pkg;

    localparam int unsigned BIAS   = 127;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;
    localparam int unsigned QBITS  = 26;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SPECIAL = 3'd1,
        DIVIDE  = 3'd2,
        ROUND   = 3'd3,
        DONE    = 3'd4
    } state_e;

    typedef struct packed {
        logic invalid;
        logic div_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } flags_t;

endpackage

// File: rtl/fp_div_mant_step.sv
// Combinational restoring-division step retiring BITS_PER_CYCLE quotient bits, MSB first.
module fp_div_mant_step
    import fp_div_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic [MANT_W+1:0]         rem_i,
    input  logic [MANT_W:0]           div_i,
    output logic [MANT_W+1:0]         rem_o,
    output logic [BITS_PER_CYCLE-1:0] q_o
);

    logic [MANT_W+1:0] r_v;

    // After a subtract the remainder is below the divisor, so the left shift never drops a set bit.
    always_comb begin
        r_v = rem_i;
        q_o = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_v >= {1'b0, div_i}) begin
                r_v = r_v - {1'b0, div_i};
                q_o[BITS_PER_CYCLE-1-i] = 1'b1;
            end
            r_v = {r_v[MANT_W:0], 1'b0};
        end
        rem_o = r_v;
    end

endmodule

// File: rtl/fp_div_seq_core.sv
// Multi-cycle binary32 divider: one-cycle special-case resolution, otherwise
// restoring mantissa division followed by round-to-nearest-even.
module fp_div_seq_core
    import fp_div_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter logic [31:0] QNAN_VALUE     = QNAN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        a_zero,
    input  logic        b_zero,
    input  logic        a_inf,
    input  logic        b_inf,
    input  logic        a_nan,
    input  logic        b_nan,
    input  logic        a_denormal,
    input  logic        b_denormal,
    input  logic        res_sign,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        flg_invalid,
    output logic        flg_div_zero,
    output logic        flg_overflow,
    output logic        flg_underflow,
    output logic        flg_inexact
);

    localparam int unsigned NCYC  = (QBITS + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(NCYC + 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [MANT_W+1:0]       rem_q, rem_d;
    logic [MANT_W:0]         div_q, div_d;
    logic [QBITS-1:0]        quo_q, quo_d;
    logic signed [9:0]       exp_q, exp_d;
    logic                    sign_q, sign_d;
    logic [31:0]             res_q, res_d;
    flags_t                  flg_q, flg_d;
    logic [31:0]             pres_q, pres_d;
    flags_t                  pflg_q, pflg_d;

    logic [MANT_W+1:0]       step_rem;
    logic [BITS_PER_CYCLE-1:0] step_q;

    fp_div_mant_step #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_step (
        .rem_i(rem_q),
        .div_i(div_q),
        .rem_o(step_rem),
        .q_o  (step_q)
    );

    // Denormal operands are flushed, so they join the zero class.
    logic a_zc, b_zc, is_special;
    logic [31:0] spec_res;
    flags_t      spec_flg;

    assign a_zc       = a_zero | a_denormal;
    assign b_zc       = b_zero | b_denormal;
    assign is_special = a_nan | b_nan | a_inf | b_inf | a_zc | b_zc;

    always_comb begin
        spec_res = '0;
        spec_flg = '0;
        if (a_nan || b_nan) begin
            spec_res         = QNAN_VALUE;
            spec_flg.invalid = (a_nan & ~a[22]) | (b_nan & ~b[22]);
        end else if ((a_inf && b_inf) || (a_zc && b_zc)) begin
            spec_res         = QNAN_VALUE;
            spec_flg.invalid = 1'b1;
        end else if (a_inf) begin
            spec_res = {res_sign, POS_INF[30:0]};
        end else if (b_inf || a_zc) begin
            spec_res = {res_sign, 31'd0};
        end else begin
            spec_res          = {res_sign, POS_INF[30:0]};
            spec_flg.div_zero = 1'b1;
        end
    end

    logic [MANT_W:0]   ma, mb;
    logic              a_lt;
    logic [MANT_W+1:0] rem_init;
    logic [9:0]        exp_init;

    assign ma       = {1'b1, a[MANT_W-1:0]};
    assign mb       = {1'b1, b[MANT_W-1:0]};
    assign a_lt     = ma < mb;
    assign rem_init = a_lt ? {ma, 1'b0} : {1'b0, ma};
    assign exp_init = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'(BIAS) - {9'd0, a_lt};

    // Quotient layout: [25:2] mantissa incl. hidden bit, [1] guard, [0] round.
    logic [MANT_W:0]   mant24;
    logic              g_bit, r_bit, s_bit, rnd_up;
    logic [MANT_W+1:0] mant_r;
    logic signed [9:0] exp_f;
    logic [31:0]       rnd_res;
    flags_t            rnd_flg;

    always_comb begin
        mant24  = quo_q[QBITS-1:2];
        g_bit   = quo_q[1];
        r_bit   = quo_q[0];
        s_bit   = |rem_q;
        rnd_up  = g_bit & (r_bit | s_bit | mant24[0]);
        mant_r  = {1'b0, mant24} + {{(MANT_W+1){1'b0}}, rnd_up};
        exp_f   = exp_q + {9'd0, mant_r[MANT_W+1]};
        rnd_flg = '0;
        rnd_flg.inexact = g_bit | r_bit | s_bit;
        if (exp_f >= 10'sd255) begin
            rnd_res          = {sign_q, POS_INF[30:0]};
            rnd_flg.overflow = 1'b1;
            rnd_flg.inexact  = 1'b1;
        end else if (exp_f <= 10'sd0) begin
            rnd_res           = {sign_q, 31'd0};
            rnd_flg.underflow = 1'b1;
            rnd_flg.inexact   = 1'b1;
        end else begin
            rnd_res = {sign_q, exp_f[EXP_W-1:0], mant_r[MANT_W-1:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        res_d   = res_q;
        flg_d   = flg_q;
        pres_d  = pres_q;
        pflg_d  = pflg_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_special) begin
                        pres_d  = spec_res;
                        pflg_d  = spec_flg;
                        state_d = SPECIAL;
                    end else begin
                        rem_d   = rem_init;
                        div_d   = mb;
                        quo_d   = '0;
                        exp_d   = exp_init;
                        sign_d  = res_sign;
                        cnt_d   = '0;
                        state_d = DIVIDE;
                    end
                end
            end
            SPECIAL: begin
                res_d   = pres_q;
                flg_d   = pflg_q;
                state_d = DONE;
            end
            DIVIDE: begin
                rem_d = step_rem;
                quo_d = {quo_q[QBITS-1-BITS_PER_CYCLE:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NCYC - 1)) state_d = ROUND;
            end
            ROUND: begin
                res_d   = rnd_res;
                flg_d   = rnd_flg;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    res_d   = '0;
                    flg_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            res_q   <= '0;
            flg_q   <= '0;
            pres_q  <= '0;
            pflg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            pres_q  <= pres_d;
            pflg_q  <= pflg_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign result        = res_q;
    assign flg_invalid   = flg_q.invalid;
    assign flg_div_zero  = flg_q.div_zero;
    assign flg_overflow  = flg_q.overflow;
    assign flg_underflow = flg_q.underflow;
    assign flg_inexact   = flg_q.inexact;

    // Operand signs arrive pre-combined as res_sign; bit 23 of the rounded mantissa is the hidden one.
    logic unused_bits;
    assign unused_bits = ^{a[31], b[31], mant_r[MANT_W]};

endmodule

// File: tb/tb_fp_div_seq_core.sv
// Directed bench for fp_div_seq_core (BITS_PER_CYCLE = 1).
module tb_fp_div_seq_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_denormal, b_denormal;
    logic        res_sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flg_invalid, flg_div_zero, flg_overflow, flg_underflow, flg_inexact;
    logic [4:0]  flg;

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    assign flg = {flg_invalid, flg_div_zero, flg_overflow, flg_underflow, flg_inexact};

    fp_div_seq_core #(
        .BITS_PER_CYCLE(1),
        .QNAN_VALUE    (32'h7FC0_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .a_zero       (a_zero),
        .b_zero       (b_zero),
        .a_inf        (a_inf),
        .b_inf        (b_inf),
        .a_nan        (a_nan),
        .b_nan        (b_nan),
        .a_denormal   (a_denormal),
        .b_denormal   (b_denormal),
        .res_sign     (res_sign),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .flg_invalid  (flg_invalid),
        .flg_div_zero (flg_div_zero),
        .flg_overflow (flg_overflow),
        .flg_underflow(flg_underflow),
        .flg_inexact  (flg_inexact)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Upstream classifier stand-in: {zero, inf, nan, denormal}.
    function automatic logic [3:0] classify(input logic [31:0] x);
        logic e_max, e_min, m_nz;
        e_max = (x[30:23] == 8'hFF);
        e_min = (x[30:23] == 8'h00);
        m_nz  = (x[22:0] != 23'd0);
        return {e_min & ~m_nz, e_max & ~m_nz, e_max & m_nz, e_min & m_nz};
    endfunction

    task automatic drive(input logic [31:0] av, input logic [31:0] bv);
        logic [3:0] ca, cb;
        ca = classify(av);
        cb = classify(bv);
        a = av;
        b = bv;
        {a_zero, a_inf, a_nan, a_denormal} = ca;
        {b_zero, b_inf, b_nan, b_denormal} = cb;
        res_sign = av[31] ^ bv[31];
        in_valid = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic start(input string tag, input logic [31:0] av, input logic [31:0] bv);
        int n;
        drive(av, bv);
        n = 0;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (!out_valid && l < 100) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] er, input logic [4:0] ef,
                              input int el);
        int l;
        wait_done(l);
        check({tag, "_lat"}, l, el);
        check({tag, "_res"}, result, er);
        check({tag, "_flg"}, {27'd0, flg}, {27'd0, ef});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(32'd0, 32'd0);
        in_valid  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {27'd0, flg}, 32'd0);

        // Flags order: {invalid, div_zero, overflow, underflow, inexact}
        start("six_by_two", 32'h40C0_0000, 32'h4000_0000);
        expect_out("six_by_two", 32'h4040_0000, 5'b00000, 27);
        start("one_by_three", 32'h3F80_0000, 32'h4040_0000);
        expect_out("one_by_three", 32'h3EAA_AAAB, 5'b00001, 27);
        start("neg_one_by_three", 32'hBF80_0000, 32'h4040_0000);
        expect_out("neg_one_by_three", 32'hBEAA_AAAB, 5'b00001, 27);

        start("one_by_zero", 32'h3F80_0000, 32'h0000_0000);
        expect_out("one_by_zero", 32'h7F80_0000, 5'b01000, 1);
        start("nzero_by_zero", 32'h8000_0000, 32'h0000_0000);
        expect_out("nzero_by_zero", 32'h7FC0_0000, 5'b10000, 1);
        start("snan_by_one", 32'h7F80_0001, 32'h3F80_0000);
        expect_out("snan_by_one", 32'h7FC0_0000, 5'b10000, 1);
        start("qnan_by_one", 32'h7FC0_0000, 32'h3F80_0000);
        expect_out("qnan_by_one", 32'h7FC0_0000, 5'b00000, 1);
        start("inf_by_inf", 32'h7F80_0000, 32'hFF80_0000);
        expect_out("inf_by_inf", 32'h7FC0_0000, 5'b10000, 1);
        start("ninf_by_two", 32'hFF80_0000, 32'h4000_0000);
        expect_out("ninf_by_two", 32'hFF80_0000, 5'b00000, 1);
        start("one_by_inf", 32'h3F80_0000, 32'h7F80_0000);
        expect_out("one_by_inf", 32'h0000_0000, 5'b00000, 1);
        start("denorm_by_two", 32'h0000_0001, 32'h4000_0000);
        expect_out("denorm_by_two", 32'h0000_0000, 5'b00000, 1);

        start("overflow", 32'h7F7F_FFFF, 32'h3F00_0000);
        expect_out("overflow", 32'h7F80_0000, 5'b00101, 27);
        start("underflow", 32'h0080_0000, 32'h4000_0000);
        expect_out("underflow", 32'h0000_0000, 5'b00011, 27);

        // Backpressure with a second operation already waiting.
        start("bp_first", 32'h40C0_0000, 32'h4000_0000);
        wait_done(lat);
        check("bp_first_lat", lat, 27);
        drive(32'h3F80_0000, 32'h4040_0000);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold_res", result, 32'h4040_0000);
            check("bp_hold_flg", {27'd0, flg}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_valid", {31'd0, out_valid}, 32'd0);
        check("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_idle_res", result, 32'd0);
        start("bp_second", 32'h3F80_0000, 32'h4040_0000);
        expect_out("bp_second", 32'h3EAA_AAAB, 5'b00001, 27);

        // Abort in the tenth DIVIDE cycle.
        start("abort", 32'h40C0_0000, 32'h4000_0000);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_result", result, 32'd0);
        start("after_abort", 32'h40C0_0000, 32'h4000_0000);
        expect_out("after_abort", 32'h4040_0000, 5'b00000, 27);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
